// File: rtl/fizzbuzz_stream_ctrl.sv
// fizzbuzz_stream_ctrl: issues a stream of FizzBuzz tokens 0..MAX_CYCLES-1
// over a valid/ready handshake. Each token carries its index and
// fizz/buzz/fizzbuzz flags. Divisibility is tracked with two wrapping modulo
// counters, so no divider is built.
// Optional build macro FIZZBUZZ_STATS_EN adds saturating per-flag transfer
// counters (fizz_cnt, buzz_cnt, fb_cnt).
module fizzbuzz_stream_ctrl #(
  parameter int FIZZ       = 3,
  parameter int BUZZ       = 5,
  parameter int MAX_CYCLES = 100,
  localparam int W         = $clog2(MAX_CYCLES)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               stop,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [W-1:0]                       out_value,
  output logic                               out_fizz,
  output logic                               out_buzz,
  output logic                               out_fizzbuzz,
  output logic                               busy,
  output logic                               done
`ifdef FIZZBUZZ_STATS_EN
  ,
  output logic [$clog2(MAX_CYCLES+1)-1:0]    fizz_cnt,
  output logic [$clog2(MAX_CYCLES+1)-1:0]    buzz_cnt,
  output logic [$clog2(MAX_CYCLES+1)-1:0]    fb_cnt
`endif
);

  // Modulo counter widths; a divisor of 1 still needs a 1-bit counter.
  localparam int FW = (FIZZ > 1) ? $clog2(FIZZ) : 1;
  localparam int BW = (BUZZ > 1) ? $clog2(BUZZ) : 1;

  localparam logic [W-1:0]  LAST  = W'(MAX_CYCLES - 1);
  localparam logic [FW-1:0] F_TOP = FW'(FIZZ - 1);
  localparam logic [BW-1:0] B_TOP = BW'(BUZZ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          launch;
  logic          xfer;
  logic          last;
  logic [FW-1:0] mod_f;
  logic [BW-1:0] mod_b;

  assign out_valid    = (state == RUN);
  assign busy         = (state == RUN);
  assign done         = (state == DONE);
  assign xfer         = out_valid && out_ready;
  assign last         = (out_value == LAST);
  assign out_fizz     = (mod_f == '0);
  assign out_buzz     = (mod_b == '0);
  assign out_fizzbuzz = out_fizz && out_buzz;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; stop always wins over start, and a start only takes
  // effect from IDLE or DONE (launch marks the edge that begins a run).
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          launch    = 1'b1;
        end
      end
      RUN: begin
        if (stop)              state_nxt = IDLE;
        else if (xfer && last) state_nxt = DONE;
      end
      DONE: begin
        if (stop) state_nxt = IDLE;
        else if (start) begin
          state_nxt = RUN;
          launch    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Token index and modulo counters: cleared on launch, advanced on every
  // transfer except the final one, where they hold on the last token.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_value <= '0;
      mod_f     <= '0;
      mod_b     <= '0;
    end else if (launch) begin
      out_value <= '0;
      mod_f     <= '0;
      mod_b     <= '0;
    end else if (xfer && !last) begin
      out_value <= out_value + W'(1);
      mod_f     <= (mod_f == F_TOP) ? '0 : mod_f + FW'(1);
      mod_b     <= (mod_b == B_TOP) ? '0 : mod_b + BW'(1);
    end
  end

`ifdef FIZZBUZZ_STATS_EN
  localparam int CW = $clog2(MAX_CYCLES + 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Per-flag transfer statistics; transfers only happen in RUN, so the
  // counters naturally hold in IDLE and DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fizz_cnt <= '0;
      buzz_cnt <= '0;
      fb_cnt   <= '0;
    end else if (launch) begin
      fizz_cnt <= '0;
      buzz_cnt <= '0;
      fb_cnt   <= '0;
    end else if (xfer) begin
      if (out_fizz)     fizz_cnt <= sat_inc(fizz_cnt);
      if (out_buzz)     buzz_cnt <= sat_inc(buzz_cnt);
      if (out_fizzbuzz) fb_cnt   <= sat_inc(fb_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fizzbuzz_stream_ctrl.sv
// Testbench for fizzbuzz_stream_ctrl (FIZZ=3, BUZZ=5, MAX_CYCLES=16).
// Directed scenarios followed by randomized start/stop/ready traffic, all
// checked against a behavioural token model. Statistics checks are compiled
// in when FIZZBUZZ_STATS_EN is defined.
module tb_fizzbuzz_stream_ctrl;

  localparam int FIZZ       = 3;
  localparam int BUZZ       = 5;
  localparam int MAX_CYCLES = 16;
  localparam int W          = $clog2(MAX_CYCLES);
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_value;
  logic         out_fizz;
  logic         out_buzz;
  logic         out_fizzbuzz;
  logic         busy;
  logic         done;
`ifdef FIZZBUZZ_STATS_EN
  logic [CW-1:0] fizz_cnt;
  logic [CW-1:0] buzz_cnt;
  logic [CW-1:0] fb_cnt;
`endif

  fizzbuzz_stream_ctrl #(
    .FIZZ(FIZZ),
    .BUZZ(BUZZ),
    .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_fizz(out_fizz),
    .out_buzz(out_buzz),
    .out_fizzbuzz(out_fizzbuzz),
    .busy(busy),
    .done(done)
`ifdef FIZZBUZZ_STATS_EN
    ,
    .fizz_cnt(fizz_cnt),
    .buzz_cnt(buzz_cnt),
    .fb_cnt(fb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: run phase (0 idle, 1 streaming, 2 finished), current
  // token index, and per-flag transfer tallies.
  int m_mode = 0;
  int m_val  = 0;
  int m_fc   = 0;
  int m_bc   = 0;
  int m_fbc  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int is_fizz(input int v);
    return ((v % FIZZ) == 0) ? 1 : 0;
  endfunction

  function automatic int is_buzz(input int v);
    return ((v % BUZZ) == 0) ? 1 : 0;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_step();
    bit x;
    x = (m_mode == 1) && out_ready;
    if (x) begin
      m_fc  += is_fizz(m_val);
      m_bc  += is_buzz(m_val);
      m_fbc += is_fizz(m_val) & is_buzz(m_val);
    end
    if (m_mode == 0) begin
      if (start && !stop) begin
        m_mode = 1; m_val = 0; m_fc = 0; m_bc = 0; m_fbc = 0;
      end
    end else if (m_mode == 1) begin
      if (stop) m_mode = 0;
      else if (x) begin
        if (m_val == MAX_CYCLES - 1) m_mode = 2;
        else                         m_val++;
      end
    end else begin
      if (stop) m_mode = 0;
      else if (start) begin
        m_mode = 1; m_val = 0; m_fc = 0; m_bc = 0; m_fbc = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_val = 0; m_fc = 0; m_bc = 0; m_fbc = 0;
  endtask

  task automatic check_all();
    chk("valid", out_valid, (m_mode == 1) ? 1 : 0);
    chk("busy",  busy,      (m_mode == 1) ? 1 : 0);
    chk("done",  done,      (m_mode == 2) ? 1 : 0);
    if (m_mode != 0) chk("value", out_value, m_val);
    if (m_mode == 1) begin
      chk("fizz", out_fizz, is_fizz(m_val));
      chk("buzz", out_buzz, is_buzz(m_val));
      chk("fizzbuzz", out_fizzbuzz, is_fizz(m_val) & is_buzz(m_val));
    end
`ifdef FIZZBUZZ_STATS_EN
    chk("fizz_cnt", fizz_cnt, m_fc);
    chk("buzz_cnt", buzz_cnt, m_bc);
    chk("fb_cnt",   fb_cnt,   m_fbc);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all();
    chk("rst_value", out_value, 0);
    chk("rst_fizz", out_fizz, 1);
    chk("rst_buzz", out_buzz, 1);
    chk("rst_fizzbuzz", out_fizzbuzz, 1);

    // Full run with ready tied high.
    start = 1'b1; cycle();
    start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < MAX_CYCLES; i++) begin
      chk("seq_value", out_value, i);
      chk("seq_fizz", out_fizz, (i % 3 == 0) ? 1 : 0);
      chk("seq_buzz", out_buzz, (i % 5 == 0) ? 1 : 0);
      chk("seq_fb", out_fizzbuzz, (i == 0 || i == 15) ? 1 : 0);
      cycle();
    end
    chk("run_done", done, 1);
    chk("run_hold_value", out_value, 15);

    // Restart from DONE, then backpressure at value 4.
    start = 1'b1; cycle();
    chk("restart_value", out_value, 0);
    start = 1'b0; cycles(4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_valid", out_valid, 1);
      chk("bp_value", out_value, 4);
      chk("bp_fizz", out_fizz, 0);
      chk("bp_buzz", out_buzz, 0);
    end
    out_ready = 1'b1; cycle();
    chk("bp_next_value", out_value, 5);
    chk("bp_next_buzz", out_buzz, 1);

    // Stop while transferring value 7.
    cycles(2);
    chk("stop_at", out_value, 7);
    stop = 1'b1; cycle();
    stop = 1'b0;
    chk("stop_valid", out_valid, 0);
    chk("stop_busy", busy, 0);
    start = 1'b1; cycle();
    chk("after_stop_value", out_value, 0);
    chk("after_stop_fb", out_fizzbuzz, 1);

    // Start held during RUN must not restart.
    cycles(5);
    chk("start_held_value", out_value, 5);
    start = 1'b0; cycles(4);
    chk("pre_reset_value", out_value, 9);

    // Asynchronous reset pulse in the middle of a cycle.
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_value", out_value, 0);
    chk("async_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_all();
    cycles(3);
    chk("no_tokens", out_valid, 0);

    // Full run for statistics, hold in DONE, start+stop in DONE.
    start = 1'b1; cycle();
    start = 1'b0; cycles(MAX_CYCLES);
    chk("stats_done", done, 1);
`ifdef FIZZBUZZ_STATS_EN
    chk("stats_fizz", fizz_cnt, 6);
    chk("stats_buzz", buzz_cnt, 4);
    chk("stats_fb", fb_cnt, 2);
`endif
    out_ready = 1'b0; cycle();
    out_ready = 1'b1; cycles(2);
    start = 1'b1; stop = 1'b1; cycle();
    chk("startstop_done", done, 0);
    chk("startstop_busy", busy, 0);
    stop = 1'b0; cycle();
`ifdef FIZZBUZZ_STATS_EN
    chk("stats_clear", fizz_cnt, 0);
`endif
    start = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
